// File: rtl/uart_msg_streamer.sv
// -----------------------------------------------------------------------------
// uart_msg_streamer
//
// Streams a programmable byte buffer into a UART transmitter using the
// dataInTx / dataInTxValid / dataInTxBusy handshake. The message length, the
// inter-byte gap and a loop mode are captured when a message starts. An abort
// request ends the message once the byte in flight has finished. Completion and
// progress are reported back to the control source.
//
// Ports
//   clk, rstn    : rising-edge clock, asynchronous active-low reset
//   wrEn/wrAddr/ : buffer write port. Writes are accepted only while idle and
//   wrData         only for addresses below DEPTH.
//   msgLen       : bytes per pass, clipped to DEPTH (sampled on start)
//   gapCycles    : idle cycles after each byte completes (sampled on start)
//   repeatMode   : 1 = loop the message until abort (sampled on start)
//   start, abort : message control
//   txData       : byte to the UART, valid while txValid=1
//   txValid      : transmit request to the UART
//   txBusy       : UART transmitter busy
//   busy         : streamer is not idle
//   done         : one-cycle pulse when a message finishes or aborts
//   aborted      : qualifies done. Held until the next accepted start.
//   sentCount    : bytes handed to the UART since the last accepted start
// -----------------------------------------------------------------------------
module uart_msg_streamer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4,
    parameter int GAP_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wrEn,
    input  logic [PTR_W-1:0]  wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [PTR_W:0]    msgLen,
    input  logic [GAP_W-1:0]  gapCycles,
    input  logic              repeatMode,
    input  logic              start,
    input  logic              abort,
    output logic [DATA_W-1:0] txData,
    output logic              txValid,
    input  logic              txBusy,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  sentCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_WAITIDLE,
        S_GAP
    } state_e;

    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W:0]     len_q, len_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               rpt_q, rpt_d;
    logic               abort_seen_q, abort_seen_d;
    logic               aborted_q, aborted_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic               tx_valid;
    logic [PTR_W:0]     eff_len;
    logic               last_byte;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    // NOTE: the buffer has no reset. Its contents are defined only by writes.
    // Leaving the reset off lets synthesis map it onto plain RAM or LUT storage.
    always_ff @(posedge clk) begin
        if (wrEn && (state_q == S_IDLE) && ({1'b0, wrAddr} < DEPTH_L)) begin
            mem_q[wrAddr] <= wrData;
        end
    end

    assign eff_len   = (msgLen > DEPTH_L) ? DEPTH_L : msgLen;
    assign last_byte = ({1'b0, ptr_q} == (len_q - (PTR_W + 1)'(1)));

    // NOTE: every signal driven here gets a default value first. Without the
    // defaults, any path that misses an assignment would infer a latch.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        len_d        = len_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        rpt_d        = rpt_q;
        abort_seen_d = abort_seen_q;
        aborted_d    = aborted_q;
        sent_d       = sent_q;
        done_d       = 1'b0;
        tx_valid     = 1'b0;

        // Abort is sticky once a message is running, so a request made
        // mid-frame is acted on at the next byte boundary.
        if ((state_q != S_IDLE) && abort) begin
            abort_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    aborted_d    = 1'b0;
                    sent_d       = '0;
                    abort_seen_d = 1'b0;
                    if (eff_len != '0) begin
                        state_d = S_ISSUE;
                        ptr_d   = '0;
                        len_d   = eff_len;
                        gap_d   = gapCycles;
                        rpt_d   = repeatMode;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                // An abort here wins over the request, so no byte leaves this cycle.
                if (abort) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (!txBusy) begin
                    tx_valid = 1'b1;
                    sent_d   = sent_q + CNT_W'(1);
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                // Gives the UART one cycle to raise txBusy before it is sampled.
                state_d = S_WAITIDLE;
            end
            S_WAITIDLE: begin
                if (!txBusy) begin
                    state_d   = S_GAP;
                    gap_cnt_d = gap_q;
                end
            end
            S_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else if (abort_seen_q || abort) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (last_byte) begin
                    if (rpt_q) begin
                        ptr_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the values from before the clock edge, so the result does not
    // depend on the order in which the always blocks run.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            len_q        <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            rpt_q        <= 1'b0;
            abort_seen_q <= 1'b0;
            aborted_q    <= 1'b0;
            done_q       <= 1'b0;
            sent_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            rpt_q        <= rpt_d;
            abort_seen_q <= abort_seen_d;
            aborted_q    <= aborted_d;
            done_q       <= done_d;
            sent_q       <= sent_d;
        end
    end

    assign txData    = mem_q[ptr_q];
    assign txValid   = tx_valid;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign sentCount = sent_q;

endmodule

// File: tb/tb_uart_msg_streamer.sv
// -----------------------------------------------------------------------------
// tb_uart_msg_streamer
//
// Directed bench for uart_msg_streamer. A small UART model accepts a byte when
// txValid is high and txBusy is low. It then holds txBusy high for FRAME
// cycles. Every byte it accepts is logged. Inputs change on the falling edge
// and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_msg_streamer;

    localparam int FRAME = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wrEn = 1'b0;
    logic [3:0]  wrAddr = '0;
    logic [7:0]  wrData = '0;
    logic [4:0]  msgLen = '0;
    logic [15:0] gapCycles = '0;
    logic        repeatMode = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  txData;
    logic        txValid;
    logic        txBusy;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] sentCount;

    int          vectors = 0;
    int          miscompares = 0;
    int          overlap = 0;
    int          busy_cnt = 0;
    logic [7:0]  cap [$];

    uart_msg_streamer #(
        .DATA_W(8), .DEPTH(16), .PTR_W(4), .GAP_W(16), .CNT_W(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .msgLen(msgLen), .gapCycles(gapCycles), .repeatMode(repeatMode),
        .start(start), .abort(abort),
        .txData(txData), .txValid(txValid), .txBusy(txBusy),
        .busy(busy), .done(done), .aborted(aborted), .sentCount(sentCount)
    );

    always #5 clk = ~clk;

    // UART transmitter model
    assign txBusy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (txValid && busy_cnt == 0) begin
            cap.push_back(txData);
            busy_cnt <= FRAME;
        end
    end

    always @(negedge clk) if (done && txValid) overlap++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wrEn = 1'b1; wrAddr = a; wrData = d;
        step();
        wrEn = 1'b0;
    endtask

    task automatic go(input logic [4:0] len, input logic [15:0] gap, input logic rpt);
        msgLen = len; gapCycles = gap; repeatMode = rpt; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin step(); n++; end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_busy(input string tag, input logic lvl, input int budget);
        int n = 0;
        while (txBusy !== lvl && n < budget) begin step(); n++; end
        check(tag, txBusy, lvl);
    endtask

    initial begin
        int n;

        // Reset state
        step(); step();
        check("rst_txValid", txValid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_sentCount", sentCount, 0);
        rstn = 1'b1;
        step();

        // Two-byte message, first byte one cycle after start
        wr(4'd0, 8'h61);
        wr(4'd1, 8'h08);
        cap.delete();
        go(5'd2, 16'd0, 1'b0);
        check("m1_latency_valid", txValid, 1);
        check("m1_latency_data", txData, 8'h61);
        wait_done("m1_done", 200);
        check("m1_aborted", aborted, 0);
        check("m1_sent", sentCount, 2);
        check("m1_ncap", cap.size(), 2);
        check("m1_b0", cap[0], 8'h61);
        check("m1_b1", cap[1], 8'h08);
        step();
        check("m1_done_pulse", done, 0);

        // Zero-length message
        cap.delete();
        go(5'd0, 16'd0, 1'b0);
        check("m0_done", done, 1);
        check("m0_busy", busy, 0);
        step();
        check("m0_done_pulse", done, 0);
        step(); step();
        check("m0_ncap", cap.size(), 0);

        // Length clipped to DEPTH
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h30 + 8'(i));
        cap.delete();
        go(5'd20, 16'd0, 1'b0);
        wait_done("clip_done", 1000);
        check("clip_sent", sentCount, 16);
        check("clip_ncap", cap.size(), 16);
        check("clip_b0", cap[0], 8'h30);
        check("clip_b15", cap[15], 8'h3f);

        // Repeat mode with abort during the second 'y'
        wr(4'd0, 8'h78); wr(4'd1, 8'h79); wr(4'd2, 8'h7a);
        cap.delete();
        go(5'd3, 16'd0, 1'b1);
        n = 0;
        while (!(cap.size() == 5 && txBusy) && n < 2000) begin step(); n++; end
        check("rpt_reach5", cap.size(), 5);
        abort = 1'b1; step(); abort = 1'b0;
        wait_done("rpt_done", 500);
        check("rpt_aborted", aborted, 1);
        check("rpt_sent", sentCount, 5);
        check("rpt_ncap", cap.size(), 5);
        check("rpt_b3", cap[3], 8'h78);
        check("rpt_b4", cap[4], 8'h79);

        // Gap of 100 cycles; write during busy is ignored
        cap.delete();
        go(5'd2, 16'd100, 1'b0);
        check("gap_aborted_clr", aborted, 0);
        wait_busy("gap_busy_hi", 1'b1, 50);
        wr(4'd0, 8'hEE);
        wait_busy("gap_busy_lo", 1'b0, 50);
        n = 0;
        while (txValid !== 1'b1 && n < 300) begin step(); n++; end
        check("gap_interval", n, 102);
        wait_done("gap_done", 500);
        check("gap_b0", cap[0], 8'h78);
        cap.delete();
        go(5'd1, 16'd0, 1'b0);
        wait_done("nowr_done", 200);
        check("nowr_b0", cap[0], 8'h78);

        // Reset mid-frame, abort while waiting in ISSUE, then replay
        step(); step();
        go(5'd3, 16'd0, 1'b0);
        wait_busy("rstm_busy_hi", 1'b1, 50);
        step();
        rstn = 1'b0;
        #1;
        check("rstm_txValid", txValid, 0);
        check("rstm_busy", busy, 0);
        check("rstm_sent", sentCount, 0);
        step();
        rstn = 1'b1;
        cap.delete();
        go(5'd3, 16'd0, 1'b0);
        check("iss_wait_valid", txValid, 0);
        check("iss_wait_busy", busy, 1);
        abort = 1'b1; step(); abort = 1'b0;
        check("iss_abort_done", done, 1);
        check("iss_abort_flag", aborted, 1);
        check("iss_abort_sent", sentCount, 0);
        check("iss_abort_ncap", cap.size(), 0);
        go(5'd3, 16'd0, 1'b0);
        wait_done("replay_done", 500);
        check("replay_ncap", cap.size(), 3);
        check("replay_b0", cap[0], 8'h78);
        check("replay_b2", cap[2], 8'h7a);
        check("replay_sent", sentCount, 3);

        check("done_txValid_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
